mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port unified memory between two requesters: port 0 = multicycle CPU
//  datapath (driven by the CPU control unit), port 1 = program loader / DMA engine.
//  Per-port req/done handshake, round-robin or fixed-priority arbitration, uniform
//  latency for reads and writes. The CPU control unit holds its FSM state until done0_o.
// PARAMETERS
//  AW          32  address width
//  DW          32  data width
//  MEM_LAT     1   memory read latency in cycles from the mem_en_o cycle (>=1)
//  FIXED_PRIO  0   0 = round-robin; 1 = port 1 always wins contention
// PORTS
//  clk           in   1   clock
//  rst           in   1   synchronous, active-high reset
//  req0_i        in   1   port 0 request; hold with we/addr/wdata stable until done0_o
//  we0_i         in   1   port 0 write (1) / read (0)
//  addr0_i       in   AW  port 0 address
//  wdata0_i      in   DW  port 0 write data
//  done0_o       out  1   port 0 completion, 1-cycle pulse
//  rdata0_o      out  DW  port 0 read data; valid from done0_o, held until next port 0 read completes
//  req1_i/we1_i/addr1_i/wdata1_i/done1_o/rdata1_o   same as port 0, for port 1
//  mem_en_o      out  1   memory command strobe
//  mem_we_o      out  1   memory write enable (only while mem_en_o)
//  mem_addr_o    out  AW  memory address
//  mem_wdata_o   out  DW  memory write data
//  mem_rdata_i   in   DW  memory read data, valid MEM_LAT cycles after mem_en_o
//  busy_o        out  1   1 when state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, owner=0, last_owner=1, wait counter=0; all outputs 0, incl. rdata0_o/rdata1_o.
//  - FSM IDLE -> CMD -> WAIT -> DONE -> IDLE.
//  - IDLE: if any req: pick winner, latch owner, we, addr, wdata into regs; -> CMD. Else stay.
//  - Winner: single requester wins. Both requesting: FIXED_PRIO=1 -> port 1; else the port
//    != last_owner. last_owner updated at grant time.
//  - CMD (1 cycle): mem_en_o=1, mem_we_o=latched we; counter loaded MEM_LAT-1; -> WAIT.
//  - WAIT: counter decrements; at counter==0 capture mem_rdata_i (reads only) into owner's rdata reg; -> DONE.
//    WAIT lasts exactly MEM_LAT cycles.
//  - DONE (1 cycle): done<owner>_o=1 (decoded from state/owner regs); -> IDLE.
//  - Latency: req sampled in IDLE at cycle T -> done at T+2+MEM_LAT; mem_en_o at T+1.
//    Back-to-back: next grant sampled in the IDLE cycle after DONE (T+3+MEM_LAT).
//  - mem_addr_o/mem_wdata_o driven from latched regs; stable from CMD through DONE; hold last value in IDLE.
//  - Write completion: done pulses, rdata of that port unchanged.
//  - req held high through done = new request, re-arbitrated in next IDLE cycle.
//  - req dropped or changed mid-transaction: ignored; latched transaction completes, done still pulses.
//  - Requests arriving while busy wait; no queueing beyond the req level.
//  - Reset mid-transaction: back to IDLE at that edge, mem_en_o/done low next cycle, transaction
//    discarded (no done), rdata regs cleared.
//  - Never more than one command in flight; done0_o and done1_o never high together.
//  - Addresses and data passed unmodified; no width conversion.
// TESTING
//  1 Port 0 read alone, MEM_LAT=1, addr=0x10, mem returns 0xDEADBEEF -> mem_en_o at T+1, done0_o at T+3, rdata0_o=0xDEADBEEF.
//  2 Both req in same cycle after reset, RR -> port 0 granted first, port 1 done 4 cycles after port 0 done;
//    repeat held reqs alternate 0,1,0,1.
//  3 FIXED_PRIO=1, both held continuously -> port 1 served every transaction, port 0 never done.
//  4 Port 1 write addr=0x20 wdata=0x55 -> single mem_en_o with mem_we_o=1, addr/wdata correct,
//    done1_o pulses, rdata1_o unchanged.
//  5 MEM_LAT=3 read -> done exactly 5 cycles after req sample; data captured from mem_rdata_i 3 cycles after mem_en_o.
//  6 rst asserted during WAIT -> next cycle busy_o=0, no done pulse, all outputs 0;
//    new req after reset serviced normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of the single-port unified memory: port 0 is the CPU datapath,
// port 1 is the loader/DMA engine. One command in flight at a time, same latency for reads and writes.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int FIXED_PRIO = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_i,
  input  logic          we0_i,
  input  logic [AW-1:0] addr0_i,
  input  logic [DW-1:0] wdata0_i,
  output logic          done0_o,
  output logic [DW-1:0] rdata0_o,
  input  logic          req1_i,
  input  logic          we1_i,
  input  logic [AW-1:0] addr1_i,
  input  logic [DW-1:0] wdata1_i,
  output logic          done1_o,
  output logic [DW-1:0] rdata1_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          busy_o
);

  // Handshake: a requester raises reqN_i with we/addr/wdata and holds them until doneN_o.
  // The request is sampled only in IDLE; doneN_o is a one-cycle pulse. A request still
  // high during the done cycle is treated as a fresh request in the following IDLE cycle.

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state;
  logic          owner;
  logic          last_owner;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [CW-1:0] cnt;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;
  logic          grant;

  // With contention, fixed priority favours the loader; otherwise the port not served last wins.
  always_comb begin
    grant = req1_i;
    if (req0_i && req1_i) begin
      grant = (FIXED_PRIO != 0) ? 1'b1 : ~last_owner;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt        <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_i || req1_i) begin
            owner      <= grant;
            last_owner <= grant;
            we_q       <= grant ? we1_i    : we0_i;
            addr_q     <= grant ? addr1_i  : addr0_i;
            wdata_q    <= grant ? wdata1_i : wdata0_i;
            state      <= CMD;
          end
        end
        CMD: begin
          cnt   <= CW'(MEM_LAT - 1);
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == '0) begin
            if (!we_q) begin
              if (owner) rdata1_q <= mem_rdata_i;
              else       rdata0_q <= mem_rdata_i;
            end
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign mem_en_o    = (state == CMD);
  assign mem_we_o    = (state == CMD) && we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign done0_o     = (state == DONE) && !owner;
  assign done1_o     = (state == DONE) && owner;
  assign rdata0_o    = rdata0_q;
  assign rdata1_o    = rdata1_q;
  assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances (LAT1 round-robin, LAT1 fixed-priority,
// LAT3 round-robin) each with a small memory model whose read data is only valid on the right cycle.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;

  logic        req0[3], we0[3], req1[3], we1[3];
  logic        done0[3], done1[3], mem_en[3], mem_we[3], busy[3];
  logic [31:0] addr0[3], wdata0[3], rdata0[3];
  logic [31:0] addr1[3], wdata1[3], rdata1[3];
  logic [31:0] mem_addr[3], mem_wdata[3], mem_rdata[3];

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : {a[15:0], 16'h5EED};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 2) ? 3 : 1;
    logic [3:0]  since;
    logic [31:0] maddr;
    int          en_cnt = 0;

    mem_port_arbiter #(
      .AW(32), .DW(32), .MEM_LAT(LAT), .FIXED_PRIO((g == 1) ? 1 : 0)
    ) dut (
      .clk(clk), .rst(rst),
      .req0_i(req0[g]), .we0_i(we0[g]), .addr0_i(addr0[g]), .wdata0_i(wdata0[g]),
      .done0_o(done0[g]), .rdata0_o(rdata0[g]),
      .req1_i(req1[g]), .we1_i(we1[g]), .addr1_i(addr1[g]), .wdata1_i(wdata1[g]),
      .done1_o(done1[g]), .rdata1_o(rdata1[g]),
      .mem_en_o(mem_en[g]), .mem_we_o(mem_we[g]), .mem_addr_o(mem_addr[g]),
      .mem_wdata_o(mem_wdata[g]), .mem_rdata_i(mem_rdata[g]), .busy_o(busy[g])
    );

    // Read data is meaningful only exactly LAT cycles after the command strobe.
    always @(posedge clk) begin
      if (rst) begin
        since <= 4'd0;
      end else if (mem_en[g]) begin
        since  <= 4'd1;
        maddr  <= mem_addr[g];
        en_cnt <= en_cnt + 1;
      end else if (since != 4'd0 && since < 4'd15) begin
        since <= since + 4'd1;
      end
    end

    assign mem_rdata[g] = (since == LAT) ? mem_fn(maddr) : (32'hBAD00000 | {28'd0, since});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int g, input bit p, input bit r, input bit w,
                       input logic [31:0] a, input logic [31:0] d);
    if (p) begin
      req1[g] = r; we1[g] = w; addr1[g] = a; wdata1[g] = d;
    end else begin
      req0[g] = r; we0[g] = w; addr0[g] = a; wdata0[g] = d;
    end
  endtask

  task automatic check_idle(input int g, input string tag);
    check({tag, "_ctl"}, {27'd0, busy[g], done0[g], done1[g], mem_en[g], mem_we[g]}, 32'd0);
    check({tag, "_addr"}, mem_addr[g], 32'd0);
    check({tag, "_wdata"}, mem_wdata[g], 32'd0);
    check({tag, "_rd0"}, rdata0[g], 32'd0);
    check({tag, "_rd1"}, rdata1[g], 32'd0);
  endtask

  // Follows instance g for ncyc cycles from the current cycle (index 0), matching each
  // done pulse against exp_q entries {port, cycle index}.
  task automatic watch(input int g, input int ncyc, input string tag);
    logic p;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (done0[g] || done1[g]) begin
        p = done1[g];
        check({tag, "_excl"}, {31'd0, done0[g] & done1[g]}, 32'd0);
        if (exp_q.size() == 0)
          check({tag, "_extra"}, {16'd0, 8'(p), 8'(i)}, 32'hFFFFFFFF);
        else
          check({tag, "_order"}, {16'd0, 8'(p), 8'(i)}, {16'd0, exp_q.pop_front()});
        check({tag, "_rdata"}, p ? rdata1[g] : rdata0[g], mem_fn(p ? addr1[g] : addr0[g]));
      end
      next();
    end
    check({tag, "_missing"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    next();
    next();
    rst = 1'b0;
  endtask

  initial begin
    int en_before;
    for (int g = 0; g < 3; g++) begin
      drive(g, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      drive(g, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    end
    do_reset();
    @(negedge clk);
    for (int g = 0; g < 3; g++) check_idle(g, $sformatf("rst%0d", g));

    // Port 0 read alone, latency 1
    next();
    drive(0, 1'b0, 1'b1, 1'b0, 32'h10, 32'd0);
    @(negedge clk);
    check("t1_en_t0", {31'd0, mem_en[0]}, 32'd0);
    next();
    @(negedge clk);
    check("t1_en", {31'd0, mem_en[0]}, 32'd1);
    check("t1_we", {31'd0, mem_we[0]}, 32'd0);
    check("t1_addr", mem_addr[0], 32'h10);
    check("t1_busy", {31'd0, busy[0]}, 32'd1);
    next();
    @(negedge clk);
    check("t1_en_wait", {31'd0, mem_en[0]}, 32'd0);
    check("t1_done_early", {31'd0, done0[0]}, 32'd0);
    next();
    req0[0] = 1'b0;
    @(negedge clk);
    check("t1_done0", {31'd0, done0[0]}, 32'd1);
    check("t1_done1", {31'd0, done1[0]}, 32'd0);
    check("t1_rdata", rdata0[0], 32'hDEADBEEF);
    next();
    @(negedge clk);
    check("t1_done_after", {31'd0, done0[0]}, 32'd0);
    check("t1_busy_after", {31'd0, busy[0]}, 32'd0);

    // Fixed priority, both held: loader wins every time
    next();
    do_reset();
    drive(1, 1'b0, 1'b1, 1'b0, 32'h0310, 32'd0);
    drive(1, 1'b1, 1'b1, 1'b0, 32'h0300, 32'd0);
    exp_q.push_back({8'd1, 8'd3});
    exp_q.push_back({8'd1, 8'd7});
    exp_q.push_back({8'd1, 8'd11});
    exp_q.push_back({8'd1, 8'd15});
    watch(1, 17, "fp");
    req0[1] = 1'b0;
    req1[1] = 1'b0;
    repeat (5) next();

    // Round-robin, both held from reset: 0,1,0,1 four cycles apart
    drive(0, 1'b0, 1'b1, 1'b0, 32'h0100, 32'd0);
    drive(0, 1'b1, 1'b1, 1'b0, 32'h0200, 32'd0);
    exp_q.push_back({8'd0, 8'd3});
    exp_q.push_back({8'd1, 8'd7});
    exp_q.push_back({8'd0, 8'd11});
    exp_q.push_back({8'd1, 8'd15});
    watch(0, 17, "rr");
    req0[0] = 1'b0;
    req1[0] = 1'b0;
    repeat (5) next();

    // Port 1 write; request dropped and address changed mid-transaction
    en_before = g_dut[0].en_cnt;
    drive(0, 1'b1, 1'b1, 1'b1, 32'h20, 32'h55);
    @(negedge clk);
    next();
    drive(0, 1'b1, 1'b0, 1'b0, 32'h99, 32'hAA);
    @(negedge clk);
    check("t4_en", {31'd0, mem_en[0]}, 32'd1);
    check("t4_we", {31'd0, mem_we[0]}, 32'd1);
    check("t4_addr", mem_addr[0], 32'h20);
    check("t4_wdata", mem_wdata[0], 32'h55);
    next();
    @(negedge clk);
    check("t4_we_wait", {31'd0, mem_we[0]}, 32'd0);
    check("t4_addr_wait", mem_addr[0], 32'h20);
    next();
    @(negedge clk);
    check("t4_done1", {31'd0, done1[0]}, 32'd1);
    check("t4_rd1_kept", rdata1[0], 32'h02005EED);
    check("t4_rd0_kept", rdata0[0], 32'h01005EED);
    next();
    @(negedge clk);
    check("t4_idle", {30'd0, busy[0], done1[0]}, 32'd0);
    check("t4_addr_hold", mem_addr[0], 32'h20);
    check("t4_single_cmd", g_dut[0].en_cnt - en_before, 32'd1);

    // Latency-3 read: done 5 cycles after sample, data from the 3rd cycle after the strobe
    next();
    drive(2, 1'b0, 1'b1, 1'b0, 32'h40, 32'd0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check($sformatf("t5_en_c%0d", i), {31'd0, mem_en[2]}, {31'd0, i == 1});
      check($sformatf("t5_done_c%0d", i), {31'd0, done0[2]}, {31'd0, i == 5});
      check($sformatf("t5_rd_c%0d", i), rdata0[2], (i >= 5) ? 32'h00405EED : 32'd0);
      next();
      if (i == 0) req0[2] = 1'b0;
    end

    // Reset during WAIT: transaction discarded, then normal service resumes
    drive(2, 1'b1, 1'b1, 1'b0, 32'h80, 32'd0);
    @(negedge clk);
    next();
    req1[2] = 1'b0;
    @(negedge clk);
    check("t6_en", {31'd0, mem_en[2]}, 32'd1);
    next();
    rst = 1'b1;
    @(negedge clk);
    check("t6_busy_pre", {31'd0, busy[2]}, 32'd1);
    next();
    rst = 1'b0;
    @(negedge clk);
    check_idle(2, "t6_rst");
    for (int i = 0; i < 5; i++) begin
      next();
      @(negedge clk);
      check($sformatf("t6_quiet_c%0d", i), {30'd0, done0[2] | done1[2], busy[2]}, 32'd0);
    end
    next();
    drive(2, 1'b0, 1'b1, 1'b0, 32'h10, 32'd0);
    exp_q.push_back({8'd0, 8'd5});
    watch(2, 7, "t6_after");
    req0[2] = 1'b0;
    repeat (6) next();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
